// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : alu_muldiv_seq                                                |
// | Brief  : Sequential RV32M-style multiply/divide unit, radix-2 iterative|
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             IsMulDiv,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int              CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       op;
  logic             neg_ab;
  logic             neg_a;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;

  // Launch-side decode
  logic             accept;
  logic             is_div_in;
  logic             a_signed_in;
  logic             b_signed_in;
  logic             sign_a_in;
  logic             sign_b_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             div_zero;
  logic             div_ovf;
  logic             skip;
  logic [WIDTH-1:0] special_res;

  assign IsMulDiv    = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign accept      = (state == IDLE) && start && IsMulDiv && !flush;
  assign is_div_in   = Funct3[2];
  assign a_signed_in = (Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
                       (Funct3 == OP_DIV)  || (Funct3 == OP_REM);
  assign b_signed_in = (Funct3 == OP_MULH) || (Funct3 == OP_DIV) || (Funct3 == OP_REM);
  assign sign_a_in   = a_signed_in && SrcA[WIDTH-1];
  assign sign_b_in   = b_signed_in && SrcB[WIDTH-1];
  assign mag_a_in    = sign_a_in ? (~SrcA + 1'b1) : SrcA;
  assign mag_b_in    = sign_b_in ? (~SrcB + 1'b1) : SrcB;

  // Signed DIV/REM have Funct3[0]=0; only those can overflow.
  assign div_zero    = is_div_in && (SrcB == '0);
  assign div_ovf     = is_div_in && !Funct3[0] && (SrcA == MOST_NEG) && (SrcB == '1);
  assign skip        = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = Funct3[1] ? SrcA : '1;
    else if (div_ovf)
      special_res = Funct3[1] ? '0 : SrcA;
  end

  // One radix-2 iteration; acc/lo hold product halves or remainder/quotient
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
  assign div_shift = {acc, lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand});
  assign div_diff  = div_shift[WIDTH-1:0] - mcand;

  always_comb begin
    acc_nxt = acc;
    lo_nxt  = lo;
    if (op[2]) begin
      acc_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_nxt  = {lo[WIDTH-2:0], div_ge};
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the post-final-iteration values as FIN is entered
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   fin_res;

  assign prod   = {acc_nxt, lo_nxt};
  assign prod_s = neg_ab ? (~prod + 1'b1) : prod;
  assign quo_s  = neg_ab ? (~lo_nxt + 1'b1) : lo_nxt;
  assign rem_s  = neg_a  ? (~acc_nxt + 1'b1) : acc_nxt;

  always_comb begin
    fin_res = '0;
    case (op)
      OP_MUL:                       fin_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fin_res = quo_s;
      OP_REM, OP_REMU:              fin_res = rem_s;
      default:                      fin_res = '0;
    endcase
  end

  logic last_iter;
  assign last_iter = (state == CALC) && (cnt == LAST_ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = skip ? FIN : CALC;
      end
      CALC: begin
        Busy = 1'b1;
        if (flush)
          state_nxt = IDLE;
        else if (cnt == LAST_ITER)
          state_nxt = FIN;
      end
      FIN: begin
        Busy      = 1'b1;
        Done      = !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      neg_ab <= 1'b0;
      neg_a  <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      Result <= '0;
    end else if (accept) begin
      op     <= Funct3;
      neg_ab <= sign_a_in ^ sign_b_in;
      neg_a  <= sign_a_in;
      acc    <= '0;
      lo     <= is_div_in ? mag_a_in : mag_b_in;
      mcand  <= is_div_in ? mag_b_in : mag_a_in;
      cnt    <= '0;
      if (skip)
        Result <= special_res;
    end else if ((state == CALC) && !flush) begin
      acc <= acc_nxt;
      lo  <= lo_nxt;
      if (cnt != LAST_ITER)
        cnt <= cnt + CW'(1);
      if (last_iter)
        Result <= fin_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_alu_muldiv_seq                                             |
// | Brief  : Directed scoreboard bench for alu_muldiv_seq (WIDTH=32)       |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_alu_muldiv_seq;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       ALUOp = 2'b00;
  logic [6:0]       Funct7 = 7'b0000001;
  logic [2:0]       Funct3 = 3'b000;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] SrcA = '0;
  logic [WIDTH-1:0] SrcB = '0;
  logic             IsMulDiv;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .start(start), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
    .IsMulDiv(IsMulDiv), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               lat;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] last_res = '0;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, ub, p;
    logic [63:0]        u;
    int                 ia, ib;
    sa = $signed(a);
    sbv = $signed(b);
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f3)
      3'b000: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'b001: begin p = sa * sbv; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return LAT;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge just after the accepting edge (cycle 1).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start_cyc);
    int   cyc;
    exp_t e;
    cyc = start_cyc;
    while (Done !== 1'b1 && cyc < 3 * LAT) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check({tag, " done"}, 64'(Done), 64'(1'b1));
    check({tag, " busy at done"}, 64'(Busy), 64'(1'b1));
    check({tag, " latency"}, 64'(cyc), 64'(e.lat));
    check({tag, " result"}, 64'(Result), 64'(e.res));
    last_res = e.res;
    @(negedge clk);
    check({tag, " done pulse"}, 64'(Done), 64'(1'b0));
    check({tag, " idle after"}, 64'(Busy), 64'(1'b0));
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    exp_t e;
    e.res = exp_res;
    e.lat = exp_lat;
    sb.push_back(e);
    issue(f3, a, b);
    wait_done(tag, 1);
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      @(negedge clk);
      if (Done === 1'b1) dones++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]      a, b;
    logic [2:0]       f3;
    int               dones;
    logic [WIDTH-1:0] prior;
    exp_t             e;

    // Reset state and decode
    @(negedge clk);
    check("reset busy", 64'(Busy), 64'(1'b0));
    check("reset done", 64'(Done), 64'(1'b0));
    check("reset result", 64'(Result), 64'(0));
    check("decode aluop00", 64'(IsMulDiv), 64'(1'b0));
    ALUOp = 2'b10;
    #1 check("decode muldiv", 64'(IsMulDiv), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op("mul 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT);
    run_op("mulhu max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);
    run_op("div -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT);
    run_op("rem -7%2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT);
    run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, LAT);
    run_op("divu by 0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("remu by 0", 3'b111, 32'h1234ABCD, 32'd0, 32'h1234ABCD, 1);
    run_op("mulh -1*-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, LAT);
    run_op("mulhsu -1*max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT);

    // Pseudo-random operands across every Funct3
    for (int i = 0; i < 16; i++) begin
      f3 = 3'(i);
      a  = $urandom;
      b  = (i == 13) ? 32'd0 : ((i > 7) ? 32'($urandom_range(1, 5000)) : $urandom);
      run_op("random", f3, a, b, model(f3, a, b), model_lat(f3, a, b));
    end

    // Stray start during a running MUL must be ignored
    e.res = 32'd3000; e.lat = LAT; sb.push_back(e);
    issue(3'b000, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    Funct3 = 3'b101; SrcA = 32'd5; SrcB = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul stray start", 10);
    count_dones(2 * LAT, dones);
    check("stray start extra done", 64'(dones), 64'(0));

    // Start with a non-M instruction is ignored
    @(negedge clk);
    Funct7 = 7'b0000000; Funct3 = 3'b000; start = 1'b1;
    #1 check("decode funct7 0", 64'(IsMulDiv), 64'(1'b0));
    @(negedge clk);
    start = 1'b0;
    check("funct7 0 no busy", 64'(Busy), 64'(1'b0));

    // Flush beats a simultaneous start
    @(negedge clk);
    Funct7 = 7'b0000001; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush over start", 64'(Busy), 64'(1'b0));

    // Flush mid-DIV: no Done, Result retained
    prior = last_res;
    issue(3'b100, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(Busy), 64'(1'b0));
    count_dones(2 * LAT, dones);
    check("flush no done", 64'(dones), 64'(0));
    check("flush result kept", 64'(Result), 64'(prior));

    // Asynchronous reset mid-CALC
    issue(3'b000, 32'd5, 32'd6);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(Busy), 64'(1'b0));
    check("async rst done", 64'(Done), 64'(1'b0));
    check("async rst result", 64'(Result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(2 * LAT, dones);
    check("rst no done", 64'(dones), 64'(0));
    run_op("after reset mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
